sram_arbiter: RTL

Two-port arbiter sharing the single data SRAM (64-bit data, 8-bit byte write enable, 1-cycle read latency) between the MEM pipeline stage (port 0) and a memory loader/debug requester (port 1). It sits between the requesters and the SRAM macro, owns the SRAM's `ena`/`wea`/`addra`/`dina` inputs, and steers `douta` back to the requester whose read was issued in the previous cycle. It provides per-port grant, optional bus locking, and a registered read-response tag.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_arb2_sel.sv | 28 ++
 rtl/sram_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port data SRAM arbiter.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin tie break).
package sram_arbiter_pkg;

    localparam int unsigned SRAM_ARB_PORTS = 2;
    localparam int unsigned SRAM_LEN_ADDR  = 64;
    localparam int unsigned SRAM_LEN_DATA  = 64;

    // Lock owner encoding, one bit per port, all-zero means no owner
    localparam logic [1:0] LOCK_NONE = 2'b00;
    localparam logic [1:0] LOCK_P0   = 2'b01;
    localparam logic [1:0] LOCK_P1   = 2'b10;

    typedef struct packed {
        logic                       req;
        logic                       lock;
        logic [SRAM_LEN_DATA/8-1:0] we;
        logic [SRAM_LEN_ADDR-1:0]   addr;
        logic [SRAM_LEN_DATA-1:0]   wdata;
    } sram_req_t;

    typedef struct packed {
        logic                     rvalid;
        logic [SRAM_LEN_DATA-1:0] rdata;
    } sram_resp_t;

endpackage

// File: rtl/sram_arbiter_arb2_sel.sv
// Pure two-port winner selection: lock owner first, then a lone requester,
// then the tie-break preference bit. Output grant is one-hot or zero.
module arb2_sel
    import sram_arbiter_pkg::*;
(
    input  logic [SRAM_ARB_PORTS-1:0] req,
    input  logic [1:0]                lock_owner,
    input  logic                      pref,
    output logic [SRAM_ARB_PORTS-1:0] gnt
);

    // Select the winner for this cycle
    always_comb begin
        gnt = '0;
        if (lock_owner == LOCK_P0 && req[0]) begin
            gnt = 2'b01;
        end else if (lock_owner == LOCK_P1 && req[1]) begin
            gnt = 2'b10;
        end else if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            gnt = pref ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared data SRAM (1-cycle read latency).
// Port 0 is the MEM stage, port 1 the loader/debug requester.
// Optional feature macro: SRAM_ARB_RR_EN selects round-robin tie break;
// without it port 0 always wins ties and no pointer flop exists.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned LEN_ADDR = 64,
    parameter int unsigned LEN_DATA = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [LEN_DATA/8-1:0] m0_we,
    input  logic [LEN_ADDR-1:0]   m0_addr,
    input  logic [LEN_DATA-1:0]   m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [LEN_DATA-1:0]   m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [LEN_DATA/8-1:0] m1_we,
    input  logic [LEN_ADDR-1:0]   m1_addr,
    input  logic [LEN_DATA-1:0]   m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [LEN_DATA-1:0]   m1_rdata,

    output logic                  sram_ena,
    output logic [LEN_DATA/8-1:0] sram_wea,
    output logic [LEN_ADDR-1:0]   sram_addra,
    output logic [LEN_DATA-1:0]   sram_dina,
    input  logic [LEN_DATA-1:0]   sram_douta
);

    logic [SRAM_ARB_PORTS-1:0] req_v;
    logic [SRAM_ARB_PORTS-1:0] gnt;
    logic [1:0]                lock_owner;
    logic                      rr_ptr;
    logic                      tag_valid;
    logic                      tag_port;
    logic                      rd_issue;

    // Requests are masked while reset is high so nothing reaches the SRAM
    assign req_v = {m1_req, m0_req} & {SRAM_ARB_PORTS{~rst}};

    arb2_sel u_sel (
        .req        (req_v),
        .lock_owner (lock_owner),
        .pref       (rr_ptr),
        .gnt        (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Steer the granted port onto the SRAM, zero the bus when idle
    always_comb begin
        sram_ena   = 1'b0;
        sram_wea   = '0;
        sram_addra = '0;
        sram_dina  = '0;
        if (gnt[0]) begin
            sram_ena   = 1'b1;
            sram_wea   = m0_we;
            sram_addra = m0_addr;
            sram_dina  = m0_wdata;
        end else if (gnt[1]) begin
            sram_ena   = 1'b1;
            sram_wea   = m1_we;
            sram_addra = m1_addr;
            sram_dina  = m1_wdata;
        end
    end

    assign rd_issue = sram_ena && (sram_wea == '0);

    // Response tag: remembers which port's read is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_port  <= 1'b0;
        end else begin
            tag_valid <= rd_issue;
            tag_port  <= gnt[1];
        end
    end

    // Lock owner: follows the granted port's lock bit; an ungranted cycle
    // means the owner (if any) dropped its request, which releases it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_owner <= LOCK_NONE;
        end else if (gnt[0]) begin
            lock_owner <= m0_lock ? LOCK_P0 : LOCK_NONE;
        end else if (gnt[1]) begin
            lock_owner <= m1_lock ? LOCK_P1 : LOCK_NONE;
        end else begin
            lock_owner <= LOCK_NONE;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Round-robin pointer: prefer the port that was not granted last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt[0]) begin
            rr_ptr <= 1'b1;
        end else if (gnt[1]) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

    assign m0_rvalid = tag_valid && !tag_port;
    assign m1_rvalid = tag_valid &&  tag_port;
    assign m0_rdata  = m0_rvalid ? sram_douta : '0;
    assign m1_rdata  = m1_rvalid ? sram_douta : '0;

endmodule
